// File: rtl/scarv_cop_mem_unit.sv
// COP load/store unit. It sits directly after the COP execute stage and issues
// one byte/halfword/word access at a time on the COP memory interface.
//
// Ports:
//   g_clk, g_reset          clock, asynchronous active-high reset
//   req_*                   request from execute (valid/ready handshake)
//   abort                   cancel the outstanding instruction
//   rsp_valid/rdata/err     single-cycle response (err: 00 ok, 01 misaligned,
//                           10 bus error, 11 illegal size)
//   cop_mem_*               word-aligned bus access with byte enables
module scarv_cop_mem_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              g_clk,
  input  logic              g_reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,

  input  logic              abort,

  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,

  output logic              cop_mem_cen,
  output logic              cop_mem_wen,
  output logic [ADDR_W-1:0] cop_mem_addr,
  output logic [31:0]       cop_mem_wdata,
  output logic [3:0]        cop_mem_ben,
  input  logic [31:0]       cop_mem_rdata,
  input  logic              cop_mem_stall,
  input  logic              cop_mem_error
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrBus      = 2'b10;
  localparam logic [1:0] ErrSize     = 2'b11;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              wen_q;
  logic [3:0]        ben_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        err_q;
  logic              abort_seen_q;

  logic        accept;
  logic        bus_done;
  logic [1:0]  req_err;
  logic [3:0]  req_ben;
  logic [31:0] req_wdata_rep;
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;

  // An abort coinciding with a request in IDLE blocks the accept.
  assign accept   = req_valid & req_ready & ~abort;
  assign bus_done = (state_q == StBus) & ~cop_mem_stall;

  // Request decode: size/alignment checks, byte enables, lane replication.
  always_comb begin
    req_err = ErrOk;
    if (req_size == 2'b11) begin
      req_err = ErrSize;
    end else if ((req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      req_err = ErrMisalign;
    end
  end

  always_comb begin
    req_ben       = 4'b1111;
    req_wdata_rep = req_wdata;
    unique case (req_size)
      2'b00: begin
        req_ben       = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_ben       = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_ben       = 4'b1111;
        req_wdata_rep = req_wdata;
      end
    endcase
  end

  // Load extraction: move the addressed lane down to bit 0, then extend.
  assign rdata_shift = cop_mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rdata_shift;
    unique case (size_q)
      2'b00:   load_ext = {{24{sext_q & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_ext = {{16{sext_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  // State register.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (req_err != ErrOk) ? StResp : StBus;
        end
      end
      StBus: begin
        // The bus access is never withdrawn; an abort only drops the response.
        if (!cop_mem_stall) begin
          state_d = (abort | abort_seen_q) ? StIdle : StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request register and response capture.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      addr_q       <= '0;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      wen_q        <= 1'b0;
      ben_q        <= 4'b0000;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= ErrOk;
      abort_seen_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        sext_q  <= req_sext;
        wen_q   <= req_wen;
        ben_q   <= req_ben;
        wdata_q <= req_wdata_rep;
        err_q   <= req_err;
        rdata_q <= 32'h0;
      end else if (bus_done) begin
        err_q   <= cop_mem_error ? ErrBus : ErrOk;
        rdata_q <= (cop_mem_error | wen_q) ? 32'h0 : load_ext;
      end
      // Remember an abort seen during a stalled transfer until it completes.
      abort_seen_q <= (state_q == StBus) & cop_mem_stall & (abort_seen_q | abort);
    end
  end

  // Outputs decoded from state so reset drops cop_mem_cen immediately.
  always_comb begin
    req_ready     = (state_q == StIdle);
    cop_mem_cen   = (state_q == StBus);
    cop_mem_wen   = 1'b0;
    cop_mem_addr  = '0;
    cop_mem_wdata = 32'h0;
    cop_mem_ben   = 4'b0000;
    rsp_valid     = 1'b0;
    rsp_err       = ErrOk;
    rsp_rdata     = 32'h0;
    if (state_q == StBus) begin
      cop_mem_wen   = wen_q;
      cop_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      cop_mem_wdata = wdata_q;
      cop_mem_ben   = ben_q;
    end
    if (state_q == StResp) begin
      rsp_valid = ~abort;
      rsp_err   = err_q;
      rsp_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_scarv_cop_mem_unit.sv
module tb_scarv_cop_mem_unit;

  logic        g_clk;
  logic        g_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        abort;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        cop_mem_cen;
  logic        cop_mem_wen;
  logic [31:0] cop_mem_addr;
  logic [31:0] cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [31:0] cop_mem_rdata;
  logic        cop_mem_stall;
  logic        cop_mem_error;

  int n_vec = 0;
  int n_err = 0;

  scarv_cop_mem_unit #(.ADDR_W(32)) dut (
    .g_clk         (g_clk),
    .g_reset       (g_reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_size      (req_size),
    .req_sext      (req_sext),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .abort         (abort),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .cop_mem_cen   (cop_mem_cen),
    .cop_mem_wen   (cop_mem_wen),
    .cop_mem_addr  (cop_mem_addr),
    .cop_mem_wdata (cop_mem_wdata),
    .cop_mem_ben   (cop_mem_ben),
    .cop_mem_rdata (cop_mem_rdata),
    .cop_mem_stall (cop_mem_stall),
    .cop_mem_error (cop_mem_error)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction. Expected values come from byte-level arithmetic.
  // abort_mode: 0 none, 1 abort in the first bus cycle, 2 abort in the response cycle.
  task automatic run_req(input logic wen, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         input logic [31:0] rdata, input logic berr, input int abort_mode);
    int          nb;
    int          off;
    logic [1:0]  e_err;
    logic [3:0]  e_ben;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    e_ben = 4'b0000;
    e_wd  = 32'h0;
    e_rd  = 32'h0;
    if (size == 2'd3) e_err = 2'b11;
    else if (off % nb != 0) e_err = 2'b01;
    else if (berr) e_err = 2'b10;
    else e_err = 2'b00;
    if (e_err == 2'b00 || e_err == 2'b10) begin
      for (int i = 0; i < nb; i++) e_ben[off + i] = 1'b1;
      for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = wdata[8*(j % nb) +: 8];
      for (int i = 0; i < nb; i++) e_rd[8*i +: 8] = rdata[8*(off + i) +: 8];
      if (sext && e_rd[8*nb - 1])
        for (int i = nb; i < 4; i++) e_rd[8*i +: 8] = 8'hFF;
    end
    if (wen || e_err != 2'b00) e_rd = 32'h0;

    @(negedge g_clk);
    check_eq("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_size  = size;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
    abort     = 1'b0;
    @(negedge g_clk);
    req_valid = 1'b0;
    req_wdata = $urandom;

    if (e_err == 2'b01 || e_err == 2'b11) begin
      check_eq("early_cen", {31'h0, cop_mem_cen}, 32'h0);
      check_eq("early_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check_eq("early_rsp_err", {30'h0, rsp_err}, {30'h0, e_err});
      check_eq("early_rsp_rdata", rsp_rdata, 32'h0);
      @(negedge g_clk);
      check_eq("early_rsp_gone", {31'h0, rsp_valid}, 32'h0);
      check_eq("early_cen_after", {31'h0, cop_mem_cen}, 32'h0);
      return;
    end

    for (int k = 0; k <= stall; k++) begin
      check_eq("bus_cen", {31'h0, cop_mem_cen}, 32'h1);
      check_eq("bus_wen", {31'h0, cop_mem_wen}, {31'h0, wen});
      check_eq("bus_addr", cop_mem_addr, {addr[31:2], 2'b00});
      check_eq("bus_ben", {28'h0, cop_mem_ben}, {28'h0, e_ben});
      if (wen) check_eq("bus_wdata", cop_mem_wdata, e_wd);
      check_eq("bus_no_rsp", {31'h0, rsp_valid}, 32'h0);
      check_eq("bus_ready", {31'h0, req_ready}, 32'h0);
      cop_mem_stall = (k < stall);
      cop_mem_rdata = (k < stall) ? $urandom : rdata;
      cop_mem_error = (k < stall) ? 1'($urandom) : berr;
      abort         = (abort_mode == 1 && k == 0);
      @(negedge g_clk);
    end
    cop_mem_stall = 1'b0;
    cop_mem_error = 1'b0;
    abort         = 1'b0;

    if (abort_mode == 1) begin
      check_eq("abort_bus_no_rsp", {31'h0, rsp_valid}, 32'h0);
      check_eq("abort_bus_cen", {31'h0, cop_mem_cen}, 32'h0);
      check_eq("abort_bus_ready", {31'h0, req_ready}, 32'h1);
      return;
    end
    if (abort_mode == 2) begin
      abort = 1'b1;
      #1;
      check_eq("abort_resp_suppr", {31'h0, rsp_valid}, 32'h0);
      @(negedge g_clk);
      abort = 1'b0;
      check_eq("abort_resp_ready", {31'h0, req_ready}, 32'h1);
      return;
    end
    check_eq("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("rsp_err", {30'h0, rsp_err}, {30'h0, e_err});
    check_eq("rsp_rdata", rsp_rdata, e_rd);
    check_eq("rsp_cen_low", {31'h0, cop_mem_cen}, 32'h0);
    @(negedge g_clk);
    check_eq("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    check_eq("ready_back", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    g_reset       = 1'b1;
    req_valid     = 1'b0;
    req_wen       = 1'b0;
    req_size      = 2'b00;
    req_sext      = 1'b0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    abort         = 1'b0;
    cop_mem_rdata = 32'h0;
    cop_mem_stall = 1'b0;
    cop_mem_error = 1'b0;
    #3;
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_cen", {31'h0, cop_mem_cen}, 32'h0);
    check_eq("rst_wen", {31'h0, cop_mem_wen}, 32'h0);
    check_eq("rst_addr", cop_mem_addr, 32'h0);
    check_eq("rst_wdata", cop_mem_wdata, 32'h0);
    check_eq("rst_ben", {28'h0, cop_mem_ben}, 32'h0);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rsp_err", {30'h0, rsp_err}, 32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge g_clk);
    g_reset = 1'b0;

    // Directed cases.
    run_req(1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);
    run_req(1'b0, 2'd0, 1'b1, 32'h2000_0003, 32'h0, 3, 32'h8012_3456, 1'b0, 0);
    run_req(1'b0, 2'd1, 1'b0, 32'h0000_0042, 32'h0, 0, 32'hABCD_1234, 1'b0, 0);
    run_req(1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'hABCD_1234, 1'b0, 0);
    run_req(1'b0, 2'd1, 1'b0, 32'h0000_0041, 32'h0, 0, 32'h0, 1'b0, 0);
    run_req(1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b0, 0);
    run_req(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00A5, 0, 32'h0, 1'b1, 0);
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h1234_5678, 1'b0, 1);
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h1234_5678, 1'b0, 0);
    run_req(1'b0, 2'd0, 1'b0, 32'h0000_0105, 32'h0, 1, 32'h1234_5678, 1'b0, 2);

    // Abort coinciding with a request in IDLE: nothing is accepted.
    @(negedge g_clk);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h0000_0200;
    abort     = 1'b1;
    @(negedge g_clk);
    req_valid = 1'b0;
    abort     = 1'b0;
    check_eq("abort_idle_cen", {31'h0, cop_mem_cen}, 32'h0);
    check_eq("abort_idle_rsp", {31'h0, rsp_valid}, 32'h0);
    check_eq("abort_idle_ready", {31'h0, req_ready}, 32'h1);

    // Reset in the middle of a stalled transfer.
    @(negedge g_clk);
    req_valid     = 1'b1;
    req_size      = 2'd2;
    req_addr      = 32'h0000_0300;
    cop_mem_stall = 1'b1;
    @(negedge g_clk);
    req_valid = 1'b0;
    check_eq("mid_rst_cen_before", {31'h0, cop_mem_cen}, 32'h1);
    #2 g_reset = 1'b1;
    #1;
    check_eq("mid_rst_cen_async", {31'h0, cop_mem_cen}, 32'h0);
    check_eq("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("mid_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    @(negedge g_clk);
    g_reset       = 1'b0;
    cop_mem_stall = 1'b0;
    repeat (2) begin
      @(negedge g_clk);
      check_eq("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      check_eq("post_rst_cen", {31'h0, cop_mem_cen}, 32'h0);
    end

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      int          am;
      int          r;
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      r  = $urandom_range(0, 9);
      am = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      run_req(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom_range(0, 3),
              $urandom, ($urandom_range(0, 7) == 0), am);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scarv_cop_mem_unit.md
Name: scarv_cop_mem_unit

Overview:
- Load/store unit directly downstream of the COP execute stage.
- Drives the COP memory interface (cop_mem_*) on behalf of COP load/store instructions.
- Accepts one byte/halfword/word request at a time and produces a word-aligned bus access with byte enables.
- Returns a single-cycle response carrying extracted, extended read data and an error code; flags misalignment before any bus access is issued.

Parameters:
- ADDR_W, 32, address width of requests and of cop_mem_addr.

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  asynchronous active-high reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit accepts request this cycle
- req_wen  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_sext  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- abort  in  1  cancel outstanding instruction (from cpu_abort_req)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_err  out  2  00 ok, 01 misaligned, 10 bus error, 11 illegal size
- cop_mem_cen  out  1  chip enable
- cop_mem_wen  out  1  write enable
- cop_mem_addr  out  ADDR_W  word-aligned address
- cop_mem_wdata  out  32  replicated write data
- cop_mem_ben  out  4  byte enables
- cop_mem_rdata  in  32  read data, valid in completing cycle
- cop_mem_stall  in  1  bus not ready; hold request
- cop_mem_error  in  1  bus error, valid in completing cycle

Behaviour:
- Reset values:
  - FSM returns to IDLE.
  - All cop_mem_* outputs, rsp_valid, rsp_err and rsp_rdata are 0.
  - req_ready is 1 (combinational from IDLE).
- FSM states:
  - IDLE: req_ready=1. An accept is req_valid & req_ready. On accept, route by request:
    - req_size=11 -> RESP, err 11.
    - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP, err 01.
    - Otherwise register addr, size, sext, wen, ben and wdata -> BUS.
  - BUS: cop_mem_cen=1; addr/wen/wdata/ben held stable.
    - Transfer completes in the first BUS cycle with cop_mem_stall=0.
    - At completion, capture cop_mem_rdata and cop_mem_error, then go to RESP.
    - While stall=1, remain in BUS.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. req_ready=0 in BUS and RESP.
- Latency without stall:
  - Accept at cycle N, bus transfer at N+1, rsp_valid at N+2.
  - Each stall cycle adds one cycle.
  - Error paths (size, misalign) respond at N+1 and never assert cop_mem_cen.
- Address: cop_mem_addr = {req_addr[ADDR_W-1:2], 2'b00}.
- Byte enables (also driven on loads):
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1]=0 -> 0011, addr[1]=1 -> 1100.
  - Word: 1111.
- Write data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata unchanged.
- Read data:
  - Shift rdata right by 8*addr[1:0], then take the low 8/16/32 bits.
  - Sign-extend if req_sext=1, else zero-extend.
  - Stores return rsp_rdata=0.
  - Any nonzero rsp_err forces rsp_rdata=0.
- Bus error: rsp_err=10; the store may have had side effects and this is not undone.
- Abort:
  - In IDLE: no effect.
  - In BUS: the bus transaction is never withdrawn; it completes, and its response is suppressed (no rsp_valid) -> IDLE.
  - In RESP: rsp_valid suppressed.
  - If abort and req_valid coincide in IDLE, the request is not accepted.
- Reset mid-operation:
  - Immediate return to IDLE, cop_mem_cen dropped asynchronously.
  - No response is emitted for the lost request.
- Only one outstanding request; no buffering beyond the single request register.

Test Plan:
- Store word, addr 0x1000_0008, wdata 0xDEADBEEF, no stall -> cen=1 at N+1 with addr 0x1000_0008, ben 1111, wen=1; rsp_valid at N+2, err 00, rdata 0.
- Load byte sext, addr 0x2000_0003, stall high 3 cycles, rdata 0x80_12_34_56 -> cen held 4 cycles with addr 0x2000_0000, ben 1000; rsp at N+5, rdata 0xFFFF_FF80.
- Load half zext, addr 0x0000_0042, rdata 0xABCD_1234 -> ben 1100, rdata 0x0000_ABCD; repeat at 0x0000_0040 -> 0x0000_1234.
- Load half at addr 0x0000_0041 -> no cen ever; rsp_valid at N+1 with err 01. Then req_size=11 -> err 11.
- Store byte 0xA5 at 0x0000_0001, cop_mem_error=1 on completion -> cop_mem_wdata 0xA5A5A5A5, ben 0010; rsp err 10.
- Abort asserted during a 2-cycle stall -> cen stays high until stall drops; no rsp_valid; next request accepted normally. Assert g_reset mid-BUS -> cen falls without a clock edge, FSM in IDLE, no response.
